// File: rtl/rll_key_loader.sv
// rll_key_loader: serial activation-key loader for the RLL-locked core.
// A key and its XOR-fold checksum arrive LSB-first over a valid/ready link.
// A verified key is driven onto key_out. Otherwise a fixed decoy key is driven,
// so the locked core keeps producing corrupted outputs.
//
// Handshake: key_in_ready is high only in SHIFT, and it comes straight from the
// state flop. A bit transfers on a rising edge where key_in_valid && key_in_ready.
// If load_start or clear_key is high in the same cycle, that transfer is dropped.
module rll_key_loader #(
   parameter int                   KEY_WIDTH = 32,
   parameter int                   CHK_WIDTH = 8,
   parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
   parameter int                   ERR_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_start,
   input  logic                 clear_key,
   input  logic                 key_in_bit,
   input  logic                 key_in_valid,
   output logic                 key_in_ready,
   output logic [KEY_WIDTH-1:0] key_out,
   output logic                 key_valid,
   output logic                 load_err,
   output logic [ERR_WIDTH-1:0] err_count,
   output logic [2:0]           fsm_state
);

   localparam int TOTAL  = KEY_WIDTH + CHK_WIDTH;
   localparam int CNT_W  = $clog2(TOTAL + 1);
   localparam int NCHUNK = KEY_WIDTH / CHK_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_CHECK = 3'd2,
      S_ARMED = 3'd3,
      S_ERROR = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [TOTAL-1:0]     shift_q, shift_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic [ERR_WIDTH-1:0] errcnt_q, errcnt_d;

   logic [CHK_WIDTH-1:0] chk_calc;
   logic [CHK_WIDTH-1:0] chk_rx;
   logic [KEY_WIDTH-1:0] key_rx;

   // The shift register fills from the top. After the last transfer the key
   // sits in the low bits and the checksum sits in the high bits.
   assign key_rx = shift_q[KEY_WIDTH-1:0];
   assign chk_rx = shift_q[TOTAL-1 -: CHK_WIDTH];

   // XOR-fold of the received key into CHK_WIDTH-bit chunks (chunk 0 = LSBs)
   always_comb begin
      chk_calc = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         chk_calc = chk_calc ^ shift_q[i*CHK_WIDTH +: CHK_WIDTH];
      end
   end

   // State and datapath registers: asynchronous reset to the decoy/idle state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         key_q    <= DECOY_KEY;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
      end
   end

   // Next-state logic. clear_key beats load_start, and both beat any handshake.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      key_d    = key_q;
      valid_d  = valid_q;
      err_d    = err_q;
      errcnt_d = errcnt_q;

      if (clear_key) begin
         state_d = S_IDLE;
         shift_d = '0;
         cnt_d   = '0;
         key_d   = DECOY_KEY;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else if (load_start) begin
         state_d = S_SHIFT;
         shift_d = '0;
         cnt_d   = '0;
         key_d   = DECOY_KEY;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            S_SHIFT: begin
               if (key_in_valid) begin
                  shift_d = {key_in_bit, shift_q[TOTAL-1:1]};
                  cnt_d   = cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(TOTAL - 1)) begin
                     state_d = S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (chk_calc == chk_rx) begin
                  state_d = S_ARMED;
                  key_d   = key_rx;
                  valid_d = 1'b1;
               end else begin
                  state_d = S_ERROR;
                  key_d   = DECOY_KEY;
                  valid_d = 1'b0;
                  err_d   = 1'b1;
                  if (errcnt_q != '1) begin
                     errcnt_d = errcnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   assign key_in_ready = (state_q == S_SHIFT);
   assign key_out      = key_q;
   assign key_valid    = valid_q;
   assign load_err     = err_q;
   assign err_count    = errcnt_q;
   assign fsm_state    = state_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// tb_rll_key_loader: directed test of the serial key loader. The drivers push
// the hand-computed result of each load into exp_q. The monitor pops an entry
// and compares it each time key_valid or load_err rises.
module tb_rll_key_loader;

   localparam int W = 70; // {key_valid, load_err, err_count[3:0], key_out[31:0], cycle[31:0]}

   logic        clk;
   logic        rst_n;
   logic        load_start;
   logic        clear_key;
   logic        key_in_bit;
   logic        key_in_valid;
   logic        key_in_ready;
   logic [31:0] key_out;
   logic        key_valid;
   logic        load_err;
   logic [3:0]  err_count;
   logic [2:0]  fsm_state;

   logic [W-1:0] exp_q[$];
   int           n_vec  = 0;
   int           n_fail = 0;
   int           cyc    = 0;
   logic [3:0]   exp_err = 4'd0;
   logic         kv_prev = 1'b0;
   logic         le_prev = 1'b0;

   rll_key_loader #(
      .KEY_WIDTH (32),
      .CHK_WIDTH (8),
      .DECOY_KEY (32'h0000_0000),
      .ERR_WIDTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .clear_key    (clear_key),
      .key_in_bit   (key_in_bit),
      .key_in_valid (key_in_valid),
      .key_in_ready (key_in_ready),
      .key_out      (key_out),
      .key_valid    (key_valid),
      .load_err     (load_err),
      .err_count    (err_count),
      .fsm_state    (fsm_state)
   );

   // Clock, cycle stamp and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: each rising key_valid/load_err is one load result
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      if (!rst_n) begin
         kv_prev = 1'b0;
         le_prev = 1'b0;
      end else begin
         if ((key_valid && !kv_prev) || (load_err && !le_prev)) begin
            n_vec++;
            a = {key_valid, load_err, err_count, key_out, cyc};
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_result got kv=%0b le=%0b ec=%0d key=%08h cyc=%0d",
                        key_valid, load_err, err_count, key_out, cyc);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL load_result got kv=%0b le=%0b ec=%0d key=%08h cyc=%0d exp kv=%0b le=%0b ec=%0d key=%08h cyc=%0d",
                           a[69], a[68], a[67:64], a[63:32], a[31:0],
                           e[69], e[68], e[67:64], e[63:32], e[31:0]);
               end
            end
         end
         kv_prev = key_valid;
         le_prev = load_err;
      end
   end

   // Direct check helper
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic pulse_start();
      key_in_valid = 1'b0;
      load_start   = 1'b1;
      @(posedge clk); #1;
      load_start   = 1'b0;
   endtask

   // Driver: serial load of key then checksum, LSB first, with an optional
   // stall after bit index stall_at. good = hand-computed checksum verdict.
   task automatic load(input logic [31:0] k, input logic [7:0] c, input bit good,
                       input bit do_start, input int stall_at, input int stall_len);
      logic [39:0] v;
      v = {c, k};
      if (do_start) pulse_start();
      for (int i = 0; i < 40; i++) begin
         key_in_valid = 1'b1;
         key_in_bit   = v[i];
         check("ready_in_shift", key_in_ready, 1'b1);
         @(posedge clk); #1;
         if (i == stall_at) begin
            key_in_valid = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               @(posedge clk); #1;
            end
         end
      end
      key_in_valid = 1'b0;
      // The result is due one clock after the edge that took the last bit.
      if (good) begin
         exp_q.push_back({1'b1, 1'b0, exp_err, k, 32'(cyc + 1)});
      end else begin
         if (exp_err != 4'hF) exp_err = exp_err + 4'd1;
         exp_q.push_back({1'b0, 1'b1, exp_err, 32'h0000_0000, 32'(cyc + 1)});
      end
      for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL result_timeout pending=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      load_start   = 1'b0;
      clear_key    = 1'b0;
      key_in_bit   = 1'b0;
      key_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_load_err", load_err, 1'b0);
      check("rst_err_count", err_count, 4'd0);
      check("rst_key_out", key_out, 32'h0000_0000);
      check("rst_ready", key_in_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", key_in_ready, 1'b0);

      // 1: good load, valid held high
      load(32'hA5C3_0F96, 8'hFF, 1'b1, 1'b1, -1, 0);
      // Armed key must not move while bits keep arriving
      for (int i = 0; i < 5; i++) begin
         key_in_valid = 1'b1;
         key_in_bit   = i[0];
         @(posedge clk); #1;
      end
      key_in_valid = 1'b0;
      check("armed_hold_key", key_out, 32'hA5C3_0F96);
      check("armed_hold_valid", key_valid, 1'b1);
      check("armed_ready", key_in_ready, 1'b0);

      // 2: same key, bad checksum
      load(32'hA5C3_0F96, 8'hFE, 1'b0, 1'b1, -1, 0);
      repeat (3) @(posedge clk); #1;
      check("error_hold_err", load_err, 1'b1);
      check("error_hold_kv", key_valid, 1'b0);
      check("error_key_out", key_out, 32'h0000_0000);
      check("error_count", err_count, 4'd1);

      // 3: stall of 3 cycles after bit 10
      load(32'h1234_5678, 8'h08, 1'b1, 1'b1, 10, 3);
      check("stall_key", key_out, 32'h1234_5678);

      // 4: abandon after 20 bits. The restart pulse carries a handshake that must be dropped.
      pulse_start();
      check("restart_kv_low", key_valid, 1'b0);
      check("restart_decoy", key_out, 32'h0000_0000);
      for (int i = 0; i < 20; i++) begin
         key_in_valid = 1'b1;
         key_in_bit   = 1'b1;
         @(posedge clk); #1;
      end
      load_start   = 1'b1;
      key_in_valid = 1'b1;
      key_in_bit   = 1'b1;
      @(posedge clk); #1;
      load_start   = 1'b0;
      load(32'hA5C3_0F96, 8'hFF, 1'b1, 1'b0, -1, 0);
      check("restart_key", key_out, 32'hA5C3_0F96);

      // 5: clear_key and load_start together; clear wins
      clear_key  = 1'b1;
      load_start = 1'b1;
      @(posedge clk); #1;
      clear_key  = 1'b0;
      load_start = 1'b0;
      check("clear_state_idle", fsm_state, 3'd0);
      check("clear_kv", key_valid, 1'b0);
      check("clear_key_out", key_out, 32'h0000_0000);
      check("clear_ready", key_in_ready, 1'b0);
      check("clear_err_kept", err_count, 4'd1);

      // 6: 17 bad loads saturate the error counter
      for (int n = 0; n < 17; n++) begin
         load(32'hA5C3_0F96, 8'h00, 1'b0, 1'b1, -1, 0);
      end
      check("err_saturated", err_count, 4'hF);

      // Asynchronous reset in the middle of a load
      pulse_start();
      for (int i = 0; i < 15; i++) begin
         key_in_valid = 1'b1;
         key_in_bit   = i[1];
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_ready", key_in_ready, 1'b0);
      check("midrst_kv", key_valid, 1'b0);
      check("midrst_err", load_err, 1'b0);
      check("midrst_count", err_count, 4'd0);
      check("midrst_key_out", key_out, 32'h0000_0000);
      check("midrst_state", fsm_state, 3'd0);
      key_in_valid = 1'b0;
      exp_err = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;

      // A fresh load must still work after the reset
      load(32'h1234_5678, 8'h08, 1'b1, 1'b1, -1, 0);
      check("post_rst_key", key_out, 32'h1234_5678);

      repeat (3) @(posedge clk); #1;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL leftover_expected pending=%0d required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
